// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID register: one outstanding imem request,
// a one-entry skid buffer for responses that arrive while decode is stalled.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o
);

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_FULL} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inflight_pc;
  logic        r_kill;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_o;
  logic        r_valid;

  logic        w_slot_free;
  logic [31:0] w_redirect_pc;

  assign w_slot_free   = !r_valid || !stall_i;
  assign w_redirect_pc = redirect_pc_i & ~32'h3;

  assign imem_req      = rst_n && (r_state == ST_REQ);
  assign imem_addr     = r_pc;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_o;
  assign pc_plus4_o    = r_pc_o + 32'd4;
  assign instr_valid_o = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_kill        <= 1'b0;
      r_buf_instr   <= NOP_INSTR;
      r_buf_pc      <= 32'h0;
      r_instr       <= NOP_INSTR;
      r_pc_o        <= 32'h0;
      r_valid       <= 1'b0;
    end else if (redirect_i) begin
      // Redirect flushes IF/ID and the skid buffer; an in-flight fetch is killed.
      r_pc    <= w_redirect_pc;
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      case (r_state)
        ST_REQ: begin
          if (imem_gnt) begin
            r_inflight_pc <= r_pc;
            r_kill        <= 1'b1;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            r_kill  <= 1'b0;
            r_state <= ST_REQ;
          end else begin
            r_kill <= 1'b1;
          end
        end
        default: r_state <= ST_REQ;
      endcase
    end else begin
      if (!stall_i) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end
      case (r_state)
        ST_REQ: begin
          if (imem_gnt) begin
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'd4;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= ST_REQ;
            end else if (w_slot_free) begin
              r_instr <= imem_rdata;
              r_pc_o  <= r_inflight_pc;
              r_valid <= 1'b1;
              r_state <= ST_REQ;
            end else begin
              r_buf_instr <= imem_rdata;
              r_buf_pc    <= r_inflight_pc;
              r_state     <= ST_FULL;
            end
          end
        end
        default: begin
          if (!stall_i) begin
            r_instr <= r_buf_instr;
            r_pc_o  <= r_buf_pc;
            r_valid <= 1'b1;
            r_state <= ST_REQ;
          end
        end
      endcase
    end
  end

endmodule
